// File: rtl/level_ctrl.sv
// Game-level sequencer: walks levels 1..MAX_LEVEL, keeps score and lives,
// and drives the level timeout counter's enable and active-low restart.
module level_ctrl #(
    parameter int HITS_PER_LEVEL = 8,
    parameter int MAX_LEVEL      = 5,
    parameter int START_LIVES    = 3,
    parameter int SCORE_W        = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               hit,
    input  logic               timeout,
    output logic [2:0]         curLevel,
    output logic               enable,
    output logic               tmr_rst_n,
    output logic [SCORE_W-1:0] score,
    output logic [1:0]         lives,
    output logic               level_up,
    output logic               game_over
);

    typedef enum logic [2:0] {IDLE, PLAY, LVLUP, MISS, OVER} state_t;

    localparam logic [3:0] LAST_HIT  = 4'(HITS_PER_LEVEL - 1);
    localparam logic [2:0] TOP_LEVEL = 3'(MAX_LEVEL);
    localparam logic [1:0] LIVES0    = 2'(START_LIVES);

    state_t             state, state_n;
    logic [3:0]         hit_cnt, cnt_n;
    logic [2:0]         lvl_n;
    logic               en_n, trn_n, lu_n, go_n;
    logic [SCORE_W-1:0] score_n;
    logic [1:0]         lives_n;
    logic [SCORE_W:0]   sum;

    assign sum = {1'b0, score} + (SCORE_W + 1)'(curLevel);

    always_comb begin
        state_n = state;
        lvl_n   = curLevel;
        en_n    = 1'b0;
        trn_n   = 1'b0;
        score_n = score;
        lives_n = lives;
        lu_n    = 1'b0;
        go_n    = 1'b0;
        cnt_n   = hit_cnt;
        unique case (state)
            IDLE, OVER: begin
                go_n = (state == OVER);
                if (start) begin
                    state_n = PLAY;
                    lvl_n   = 3'd1;
                    score_n = '0;
                    lives_n = LIVES0;
                    cnt_n   = 4'd0;
                    en_n    = 1'b1;
                    trn_n   = 1'b1;
                    go_n    = 1'b0;
                end
            end
            PLAY: begin
                en_n  = 1'b1;
                trn_n = 1'b1;
                if (hit) begin
                    // A simultaneous timeout is dropped: the hit restarts the timer.
                    score_n = sum[SCORE_W] ? '1 : sum[SCORE_W-1:0];
                    trn_n   = 1'b0;
                    if (hit_cnt == LAST_HIT) begin
                        cnt_n = 4'd0;
                        if (curLevel < TOP_LEVEL) begin
                            state_n = LVLUP;
                            lvl_n   = curLevel + 3'd1;
                            lu_n    = 1'b1;
                            en_n    = 1'b0;
                        end
                    end else begin
                        cnt_n = hit_cnt + 4'd1;
                    end
                end else if (timeout) begin
                    en_n    = 1'b0;
                    trn_n   = 1'b0;
                    lives_n = lives - 2'd1;
                    if (lives == 2'd1) begin
                        state_n = OVER;
                        go_n    = 1'b1;
                    end else begin
                        state_n = MISS;
                    end
                end
            end
            LVLUP, MISS: begin
                state_n = PLAY;
                en_n    = 1'b1;
                trn_n   = 1'b1;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            curLevel  <= 3'd1;
            enable    <= 1'b0;
            tmr_rst_n <= 1'b0;
            score     <= '0;
            lives     <= LIVES0;
            level_up  <= 1'b0;
            game_over <= 1'b0;
            hit_cnt   <= 4'd0;
        end else begin
            state     <= state_n;
            curLevel  <= lvl_n;
            enable    <= en_n;
            tmr_rst_n <= trn_n;
            score     <= score_n;
            lives     <= lives_n;
            level_up  <= lu_n;
            game_over <= go_n;
            hit_cnt   <= cnt_n;
        end
    end

endmodule

// File: tb/tb_level_ctrl.sv
// Directed bench for level_ctrl: vector table plus hand-written level,
// saturation and mid-game reset sequences.
module tb_level_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic hit = 1'b0;
    logic timeout = 1'b0;

    logic [2:0] lvl, lvl4;
    logic       en, en4, trn, trn4, lu, lu4, go, go4;
    logic [7:0] sc;
    logic [3:0] sc4;
    logic [1:0] lv, lv4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    level_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .hit(hit), .timeout(timeout),
        .curLevel(lvl), .enable(en), .tmr_rst_n(trn), .score(sc),
        .lives(lv), .level_up(lu), .game_over(go)
    );

    level_ctrl #(.SCORE_W(4)) dut4 (
        .clk(clk), .rst(rst), .start(start), .hit(hit), .timeout(timeout),
        .curLevel(lvl4), .enable(en4), .tmr_rst_n(trn4), .score(sc4),
        .lives(lv4), .level_up(lu4), .game_over(go4)
    );

    typedef struct {
        logic       s, h, t;
        logic [2:0] lvl;
        logic       en, trn;
        logic [7:0] sc;
        logic [1:0] lv;
        logic       lu, go;
    } vec_t;

    vec_t tbl[28];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int e_lvl, input int e_en,
                           input int e_trn, input int e_sc, input int e_lv,
                           input int e_lu, input int e_go);
        chk({tag, ".curLevel"}, int'(lvl), e_lvl);
        chk({tag, ".enable"}, int'(en), e_en);
        chk({tag, ".tmr_rst_n"}, int'(trn), e_trn);
        chk({tag, ".score"}, int'(sc), e_sc);
        chk({tag, ".lives"}, int'(lv), e_lv);
        chk({tag, ".level_up"}, int'(lu), e_lu);
        chk({tag, ".game_over"}, int'(go), e_go);
    endtask

    task automatic step(input logic s, input logic h, input logic t);
        start   = s;
        hit     = h;
        timeout = t;
        @(posedge clk);
        #1;
        start   = 1'b0;
        hit     = 1'b0;
        timeout = 1'b0;
    endtask

    function automatic vec_t v(input logic s, h, t, input int l, e, r,
                               input int c, input int li, input int u, g);
        vec_t x;
        x.s = s; x.h = h; x.t = t;
        x.lvl = 3'(l); x.en = e[0]; x.trn = r[0];
        x.sc = 8'(c); x.lv = 2'(li); x.lu = u[0]; x.go = g[0];
        return x;
    endfunction

    int exp_sc;
    int exp_sc4;

    initial begin
        //            s  h  t  lvl en trn sc lv lu go
        tbl[0]  = v(1, 0, 0, 1, 1, 1, 0, 3, 0, 0);
        for (int k = 1; k <= 7; k++)
            tbl[k] = v(0, 1, 0, 1, 1, 0, k, 3, 0, 0);
        tbl[8]  = v(0, 1, 0, 2, 0, 0, 8, 3, 1, 0);
        tbl[9]  = v(0, 0, 0, 2, 1, 1, 8, 3, 0, 0);
        tbl[10] = v(0, 0, 0, 2, 1, 1, 8, 3, 0, 0);
        tbl[11] = v(0, 0, 1, 2, 0, 0, 8, 2, 0, 0);
        tbl[12] = v(1, 0, 0, 2, 1, 1, 8, 2, 0, 0);
        tbl[13] = v(0, 1, 0, 2, 1, 0, 10, 2, 0, 0);
        tbl[14] = v(0, 1, 1, 2, 1, 0, 12, 2, 0, 0);
        tbl[15] = v(0, 0, 1, 2, 0, 0, 12, 1, 0, 0);
        tbl[16] = v(0, 0, 0, 2, 1, 1, 12, 1, 0, 0);
        tbl[17] = v(0, 1, 1, 2, 1, 0, 14, 1, 0, 0);
        tbl[18] = v(0, 0, 1, 2, 0, 0, 14, 0, 0, 1);
        tbl[19] = v(0, 1, 0, 2, 0, 0, 14, 0, 0, 1);
        tbl[20] = v(0, 0, 1, 2, 0, 0, 14, 0, 0, 1);
        tbl[21] = v(1, 0, 0, 1, 1, 1, 0, 3, 0, 0);
        tbl[22] = v(0, 0, 1, 1, 0, 0, 0, 2, 0, 0);
        tbl[23] = v(0, 0, 0, 1, 1, 1, 0, 2, 0, 0);
        tbl[24] = v(0, 0, 1, 1, 0, 0, 0, 1, 0, 0);
        tbl[25] = v(0, 0, 0, 1, 1, 1, 0, 1, 0, 0);
        tbl[26] = v(0, 0, 1, 1, 0, 0, 0, 0, 0, 1);
        tbl[27] = v(1, 0, 0, 1, 1, 1, 0, 3, 0, 0);

        // reset for two cycles, then idle without start
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk_all("reset", 1, 0, 0, 0, 3, 0, 0);
        rst = 1'b0;
        step(0, 1, 1);
        chk_all("idle_ignore", 1, 0, 0, 0, 3, 0, 0);

        foreach (tbl[i]) begin
            step(tbl[i].s, tbl[i].h, tbl[i].t);
            chk_all($sformatf("vec%0d", i), tbl[i].lvl, tbl[i].en, tbl[i].trn,
                    tbl[i].sc, tbl[i].lv, tbl[i].lu, tbl[i].go);
        end

        // climb L1..L4 to L5, then hits at L5 must not advance
        exp_sc  = 0;
        exp_sc4 = 0;
        for (int l = 1; l <= 4; l++) begin
            for (int k = 1; k <= 8; k++) begin
                step(0, 1, 0);
                exp_sc  += l;
                exp_sc4 = (exp_sc4 + l > 15) ? 15 : exp_sc4 + l;
                chk($sformatf("sat4_L%0d_h%0d", l, k), int'(sc4), exp_sc4);
            end
            chk_all($sformatf("lvlup%0d", l), l + 1, 0, 0, exp_sc, 3, 1, 0);
            step(0, 0, 0);
            chk_all($sformatf("after_lvlup%0d", l), l + 1, 1, 1, exp_sc, 3, 0, 0);
        end
        for (int k = 1; k <= 10; k++) begin
            step(0, 1, 0);
            exp_sc += 5;
            chk_all($sformatf("L5_h%0d", k), 5, 1, 0, exp_sc, 3, 0, 0);
            chk($sformatf("L5_sat4_h%0d", k), int'(sc4), 15);
        end

        // narrow-score instance: 20 hits from a fresh game saturates at 15
        rst = 1'b1;
        step(0, 0, 0);
        rst = 1'b0;
        step(1, 0, 0);
        exp_sc4 = 0;
        for (int k = 1; k <= 20; k++) begin
            step(0, 1, 0);
            exp_sc4 = (exp_sc4 + ((k > 8) ? 2 : 1) > 15) ? 15 : exp_sc4 + ((k > 8) ? 2 : 1);
            if (k == 9) exp_sc4 = 10;
            step(0, 0, 0);
        end
        chk("sat4_final", int'(sc4), 15);
        chk("sat4_level", int'(lvl4), 3);

        // reset in the middle of PLAY
        step(0, 1, 0);
        step(0, 0, 1);
        rst = 1'b1;
        step(0, 1, 0);
        chk_all("mid_rst", 1, 0, 0, 0, 3, 0, 0);
        chk("mid_rst_sc4", int'(sc4), 0);
        rst = 1'b0;
        step(0, 0, 0);
        chk_all("post_rst_idle", 1, 0, 0, 0, 3, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
